imem_loader: RTL

//  Boot-time program loader upstream of the rv32i core. Takes a byte stream (valid/ready),

---
 rtl/loader_pkg.sv | 26 ++
 rtl/byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state).
package loader_pkg;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      LEN_LO = 3'd0,
      LEN_HI = 3'd1,
      DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      CSUM   = 3'd3,
`endif
      RUN    = 3'd4,
      ERR    = 3'd5
   } loaderState_t;

   // True when a requested word count does not fit a memory of 2**addrW words.
   function automatic logic lenTooBig(input logic [15:0] n, input int addrW);
      logic [31:0] capacity;
      capacity  = 32'd1 << addrW;
      lenTooBig = ({16'd0, n} > capacity);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian 32-bit words.
// word_valid pulses for one cycle, the cycle after the 4th byte is taken.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_lane,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  lane;
   logic [23:0] partial;

   assign last_lane = (lane == 2'(BYTES_PER_WORD - 1));

   // Lane steering; the final byte completes the word directly into the output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane       <= 2'd0;
         partial    <= 24'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (byte_valid) begin
            lane <= lane + 2'd1;
            case (lane)
               2'd0:    partial[7:0]   <= byte_data;
               2'd1:    partial[15:8]  <= byte_data;
               2'd2:    partial[23:16] <= byte_data;
               default: begin
                  word       <= {byte_data, partial};
                  word_valid <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, packed data words into instruction memory,
// then releases the core with a fixed start PC.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
//
// state  | meaning
// LEN_LO | waiting for word count low byte
// LEN_HI | waiting for word count high byte
// DATA   | packing data bytes, writing words
// CSUM   | waiting for checksum byte (checksum build only)
// RUN    | load finished, core released
// ERR    | load aborted, core held in reset
module imem_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              core_reset,
   output logic [31:0]       core_pc,
   output logic              done,
   output logic              err
);

   loaderState_t state;
   logic [15:0]  wordCount;
   logic [15:0]  wordIdx;
   logic [15:0]  lenFull;
   logic         accept;
   logic         packByte;
   logic         lastLane;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]   csum;
`endif

   assign accept   = rx_valid & rx_ready;
   assign packByte = accept && (state == DATA);
   assign lenFull  = {rx_data, wordCount[7:0]};
   assign core_pc  = RESET_PC;

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (packByte),
      .byte_data  (rx_data),
      .last_lane  (lastLane),
      .word_valid (im_we),
      .word       (im_wdata)
   );

   // Loader FSM with word counter and registered handshake/status outputs.
   // done/core_reset follow RUN by one cycle so release lands after the last im_we.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LEN_LO;
         wordCount  <= 16'd0;
         wordIdx    <= 16'd0;
         im_addr    <= '0;
         rx_ready   <= 1'b1;
         core_reset <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         case (state)
            LEN_LO: begin
               if (accept) begin
                  wordCount[7:0] <= rx_data;
                  state          <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (accept) begin
                  wordCount[15:8] <= rx_data;
                  if (lenFull == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     state    <= CSUM;
`else
                     state    <= RUN;
                     rx_ready <= 1'b0;
`endif
                  end else if (lenTooBig(lenFull, ADDR_W)) begin
                     state    <= ERR;
                     rx_ready <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ rx_data;
`endif
                  if (lastLane) begin
                     im_addr <= wordIdx[ADDR_W-1:0];
                     wordIdx <= wordIdx + 16'd1;
                     if (wordIdx == wordCount - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= CSUM;
`else
                        state    <= RUN;
                        rx_ready <= 1'b0;
`endif
                     end
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  rx_ready <= 1'b0;
                  if (rx_data == csum) begin
                     state <= RUN;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            RUN: begin
               core_reset <= 1'b0;
               done       <= 1'b1;
            end
            ERR: begin
               rx_ready <= 1'b0;
            end
            default: begin
               state    <= ERR;
               rx_ready <= 1'b0;
               err      <= 1'b1;
            end
         endcase
      end
   end

endmodule
